// File: rtl/game_pkg.sv
// Shared screen geometry and sprite-controller types for the game datapath.
package game_pkg;

    localparam int unsigned SCREEN_W   = 1024;
    localparam int unsigned SCREEN_H   = 768;
    localparam int unsigned TOM_WIDTH  = 64;
    localparam int unsigned TOM_HEIGHT = 64;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } tom_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: combinational pulse for same-edge use plus a registered copy.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic rise_q
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d;
            rise_q <= rise;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/tom_move_ctl.sv
// Tom sprite motion controller: per-frame button sampling, horizontal clamp,
// and a ground/rise/fall jump machine with integer kinematics.
module tom_move_ctl
    import game_pkg::*;
#(
    parameter int unsigned X_INIT  = 100,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = SCREEN_W - TOM_WIDTH,
    parameter int unsigned Y_MAX   = 400,
    parameter int unsigned STEP    = 4,
    parameter int unsigned JUMP_V0 = 16,
    parameter int unsigned GRAVITY = 1,
    parameter int unsigned V_MAX   = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] tom_x,
    output logic [9:0] tom_y,
    output logic       tom_dir,
    output tom_state_t tom_state,
    output logic       frame_tick
);

    localparam logic [10:0] XLO_11  = 11'(X_MIN + STEP);
    localparam logic [10:0] XMAX_11 = 11'(X_MAX);
    localparam logic [10:0] STEP_11 = 11'(STEP);
    localparam logic [10:0] YMAX_11 = 11'(Y_MAX);
    localparam logic [9:0]  XMIN_10 = 10'(X_MIN);
    localparam logic [9:0]  XMAX_10 = 10'(X_MAX);
    localparam logic [9:0]  STEP_10 = 10'(STEP);
    localparam logic [9:0]  YMAX_10 = 10'(Y_MAX);
    localparam logic [9:0]  V0_10   = 10'(JUMP_V0);
    localparam logic [5:0]  V1_6    = 6'(JUMP_V0 - GRAVITY);
    localparam logic [5:0]  G_6     = 6'(GRAVITY);
    localparam logic [6:0]  G_7     = 7'(GRAVITY);
    localparam logic [6:0]  VMAX_7  = 7'(V_MAX);

    logic       tick;
    logic       armed, armed_next;
    logic [5:0] vel, vel_next;
    logic [9:0] x_next, y_next;
    logic       dir_next;
    tom_state_t state_next;

    logic        launch;
    logic [10:0] rise_sum;
    logic        rise_top;
    logic [5:0]  rise_vel;
    logic [6:0]  fall_sum;
    logic [5:0]  fall_vn;
    logic        fall_land;

    rise_edge_det u_frame_edge (
        .clk    (clk),
        .rst    (rst),
        .d      (vblnk),
        .rise   (tick),
        .rise_q (frame_tick)
    );

    assign launch    = btn_jump & armed;
    assign rise_sum  = {1'b0, tom_y} + {5'b0, vel};
    assign rise_top  = (rise_sum >= YMAX_11);
    assign rise_vel  = (vel > G_6) ? vel - G_6 : '0;
    assign fall_sum  = {1'b0, vel} + G_7;
    assign fall_vn   = (fall_sum > VMAX_7) ? VMAX_7[5:0] : fall_sum[5:0];
    assign fall_land = ({1'b0, tom_y} <= {5'b0, fall_vn});

    always_ff @(posedge clk) begin
        if (rst) begin
            tom_state <= GROUND;
            tom_x     <= 10'(X_INIT);
            tom_y     <= '0;
            tom_dir   <= 1'b0;
            vel       <= '0;
            armed     <= 1'b0;
        end else begin
            tom_state <= state_next;
            tom_x     <= x_next;
            tom_y     <= y_next;
            tom_dir   <= dir_next;
            vel       <= vel_next;
            armed     <= armed_next;
        end
    end

    always_comb begin
        state_next = tom_state;
        if (tick) begin
            unique case (tom_state)
                GROUND:  if (launch) state_next = RISE;
                RISE:    if (rise_top || rise_vel == '0) state_next = FALL;
                FALL:    if (fall_land) state_next = GROUND;
                default: state_next = GROUND;
            endcase
        end
    end

    always_comb begin
        y_next     = tom_y;
        vel_next   = vel;
        armed_next = armed;
        if (tick) begin
            if (!btn_jump) armed_next = 1'b1;
            unique case (tom_state)
                GROUND: begin
                    if (launch) begin
                        y_next     = V0_10;
                        vel_next   = V1_6;
                        armed_next = 1'b0;
                    end else begin
                        y_next   = '0;
                        vel_next = '0;
                    end
                end
                RISE: begin
                    if (rise_top) begin
                        y_next   = YMAX_10;
                        vel_next = '0;
                    end else begin
                        y_next   = rise_sum[9:0];
                        vel_next = rise_vel;
                    end
                end
                FALL: begin
                    if (fall_land) begin
                        y_next   = '0;
                        vel_next = '0;
                    end else begin
                        y_next   = tom_y - {4'b0, fall_vn};
                        vel_next = fall_vn;
                    end
                end
                default: begin
                    y_next   = '0;
                    vel_next = '0;
                end
            endcase
        end
    end

    // Clamp tests are done on the unmoved 11-bit position so a step past 0 never wraps.
    always_comb begin
        x_next   = tom_x;
        dir_next = tom_dir;
        if (tick) begin
            if (btn_left && !btn_right) begin
                dir_next = 1'b1;
                x_next   = ({1'b0, tom_x} < XLO_11) ? XMIN_10 : tom_x - STEP_10;
            end else if (btn_right && !btn_left) begin
                dir_next = 1'b0;
                x_next   = ({1'b0, tom_x} + STEP_11 > XMAX_11) ? XMAX_10 : tom_x + STEP_10;
            end
        end
    end

endmodule

// File: tb/tb_tom_move_ctl.sv
// Bench for tom_move_ctl: vector table, hand sequences and a random run against a trajectory model.
module tb_tom_move_ctl;
    import game_pkg::*;

    localparam int X_INIT  = 100;
    localparam int X_MIN   = 0;
    localparam int X_MAX   = 960;
    localparam int Y_MAX   = 400;
    localparam int STEP    = 4;
    localparam int JUMP_V0 = 16;
    localparam int GRAVITY = 1;
    localparam int V_MAX   = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblnk = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [9:0] tom_x, tom_y;
    logic       tom_dir, frame_tick;
    tom_state_t tom_state;

    int checks = 0;
    int errors = 0;

    tom_move_ctl #(
        .X_INIT (X_INIT), .X_MIN (X_MIN), .X_MAX (X_MAX), .Y_MAX (Y_MAX),
        .STEP (STEP), .JUMP_V0 (JUMP_V0), .GRAVITY (GRAVITY), .V_MAX (V_MAX)
    ) dut (
        .clk (clk), .rst (rst), .vblnk (vblnk),
        .btn_left (btn_left), .btn_right (btn_right), .btn_jump (btn_jump),
        .tom_x (tom_x), .tom_y (tom_y), .tom_dir (tom_dir),
        .tom_state (tom_state), .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: x/dir by arithmetic, jump as an index into a precomputed height profile.
    int traj_y[$];
    int traj_s[$];
    int mx, mdir, midx;
    bit marmed;

    function automatic void build_traj();
        int y, v, s, vn;
        y = JUMP_V0; v = JUMP_V0 - GRAVITY; s = 1;
        traj_y.push_back(y); traj_s.push_back(s);
        for (int n = 0; n < 1000 && s != 0; n++) begin
            if (s == 1) begin
                if (y + v >= Y_MAX) begin y = Y_MAX; v = 0; s = 2; end
                else begin
                    y = y + v;
                    v = (v > GRAVITY) ? v - GRAVITY : 0;
                    if (v == 0) s = 2;
                end
            end else begin
                vn = (v + GRAVITY > V_MAX) ? V_MAX : v + GRAVITY;
                if (y <= vn) begin y = 0; v = 0; s = 0; end
                else begin y = y - vn; v = vn; end
            end
            traj_y.push_back(y); traj_s.push_back(s);
        end
    endfunction

    function automatic void model_reset();
        mx = X_INIT; mdir = 0; midx = -1; marmed = 1'b0;
    endfunction

    function automatic void model_step(input bit l, input bit r, input bit j);
        if (l && !r) begin
            mx = mx - STEP; if (mx < X_MIN) mx = X_MIN; mdir = 1;
        end else if (r && !l) begin
            mx = mx + STEP; if (mx > X_MAX) mx = X_MAX; mdir = 0;
        end
        if (midx < 0) begin
            if (j && marmed) begin midx = 0; marmed = 1'b0; end
        end else begin
            midx++;
            if (traj_s[midx] == 0) midx = -1;
        end
        if (!j) marmed = 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int x, input int y, input int d, input int s);
        check({tag, ".x"},   32'(tom_x), 32'(x));
        check({tag, ".y"},   32'(tom_y), 32'(y));
        check({tag, ".dir"}, 32'(tom_dir), 32'(d));
        check({tag, ".st"},  32'(tom_state), 32'(s));
    endtask

    task automatic check_model(input string tag);
        check_out(tag, mx, (midx < 0) ? 0 : traj_y[midx], mdir, (midx < 0) ? 0 : traj_s[midx]);
    endtask

    task automatic do_reset(input logic vb);
        @(negedge clk);
        rst = 1'b1; vblnk = vb;
        @(negedge clk);
        check_out("reset", X_INIT, 0, 0, 0);
        check("reset.tick", 32'(frame_tick), 32'd0);
        rst = 1'b0; vblnk = 1'b0;
        model_reset();
    endtask

    // One frame: buttons valid at the tick edge; optional button noise afterwards.
    task automatic do_frame(input bit l, input bit r, input bit j, input bit g);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_jump = j; vblnk = 1'b1;
        @(negedge clk);
        check("tick.hi", 32'(frame_tick), 32'd1);
        if (g) begin btn_left = ~l; btn_right = ~r; btn_jump = ~j; end
        @(negedge clk);
        check("tick.lo", 32'(frame_tick), 32'd0);
        vblnk = 1'b0;
        if (g) begin btn_left = $urandom_range(0, 1); btn_right = $urandom_range(0, 1); end
        @(negedge clk);
        @(negedge clk);
        model_step(l, r, j);
    endtask

    typedef struct {
        bit l, r, j, g;
        int n;
        int x, y, dir, st;
    } vec_t;

    vec_t tbl[11];

    initial begin
        build_traj();
        model_reset();

        tbl[0]  = '{0, 0, 0, 0,  5, 100,   0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1,  3, 112,   0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0,  1, 108,   0, 1, 0};
        tbl[3]  = '{1, 1, 0, 0,  2, 108,   0, 1, 0};
        tbl[4]  = '{0, 0, 0, 1,  1, 108,   0, 1, 0};
        tbl[5]  = '{0, 1, 1, 0,  1, 112,  16, 0, 1};
        tbl[6]  = '{0, 1, 1, 0, 15, 172, 136, 0, 2};
        tbl[7]  = '{0, 1, 1, 0, 16, 236,   0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0,  3, 236,   0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,  1, 236,   0, 0, 0};
        tbl[10] = '{0, 0, 1, 0,  1, 236,  16, 0, 1};

        do_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].n; k++) do_frame(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].g);
            check_out($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].st);
        end

        // Reset at the apex, coinciding with a tick edge, while jump stays held.
        do_reset(1'b0);
        do_frame(0, 0, 0, 0);
        for (int k = 0; k < 16; k++) do_frame(0, 1, 1, 0);
        check_out("apex", 164, 136, 0, 2);
        btn_jump = 1'b1;
        do_reset(1'b1);
        do_frame(0, 0, 1, 0);
        do_frame(0, 0, 1, 0);
        check_out("rearm.held", 100, 0, 0, 0);
        do_frame(0, 0, 0, 0);
        do_frame(0, 0, 1, 0);
        check_out("rearm.jump", 100, 16, 0, 1);

        // Horizontal clamps at both screen edges.
        do_reset(1'b0);
        for (int k = 0; k < 25; k++) do_frame(1, 0, 0, 0);
        check_out("left.edge", 0, 0, 1, 0);
        do_frame(1, 0, 0, 0);
        check_out("left.clamp", 0, 0, 1, 0);
        for (int k = 0; k < 240; k++) do_frame(0, 1, 0, 0);
        check_out("right.edge", X_MAX, 0, 0, 0);
        do_frame(0, 1, 0, 0);
        check_out("right.clamp", X_MAX, 0, 0, 0);
        do_frame(1, 1, 0, 0);
        check_out("both", X_MAX, 0, 0, 0);

        // Random frames against the model.
        do_reset(1'b0);
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 79) == 0) do_reset(1'b0);
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            check_model($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
